// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: counters, sync/blank, line/frame strobes, raster irq.
// Optional build macro VIDEO_TIMING_SYNC_SHIFT_EN enables per-frame hsync/vsync window shifting.
module video_timing_gen #(
  parameter int HW      = 10,
  parameter int VW      = 9,
  parameter int H_START = 128,
  parameter int H_FP    = 40,
  parameter int H_SYNC  = 32,
  parameter int H_BP    = 56,
  parameter int H_DISP  = 256,
  parameter int V_START = 248,
  parameter int V_FP    = 16,
  parameter int V_SYNC  = 8,
  parameter int V_BP    = 16,
  parameter int V_DISP  = 224,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cen,
  input  logic [VW-1:0] irq_line,
  input  logic          irq_en,
  input  logic          irq_ack,
  input  logic [3:0]    h_shift,
  input  logic [3:0]    v_shift,
  output logic [HW-1:0] video_pos_x,
  output logic [VW-1:0] video_pos_y,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank,
  output logic          enable,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_cnt,
  output logic          irq
);

  localparam int H_TOT  = H_FP + H_SYNC + H_BP + H_DISP;
  localparam int V_TOT  = V_FP + V_SYNC + V_BP + V_DISP;
  localparam int H_LAST = H_START + H_TOT - 1;
  localparam int V_LAST = V_START + V_TOT - 1;
  localparam int H_BLK  = H_FP + H_SYNC + H_BP;
  localparam int V_BLK  = V_FP + V_SYNC + V_BP;

  if (H_LAST >= (1 << HW)) begin : g_bad_hw
    $error("video_timing_gen: H_START+H_TOT-1 does not fit in HW bits");
  end
  if (V_LAST >= (1 << VW)) begin : g_bad_vw
    $error("video_timing_gen: V_START+V_TOT-1 does not fit in VW bits");
  end

  localparam logic [HW-1:0] X_FIRST  = HW'(H_START);
  localparam logic [HW-1:0] X_LAST   = HW'(H_LAST);
  localparam logic [HW-1:0] X_PRE_HS = HW'(H_START + H_FP - 1);
  localparam logic [VW-1:0] Y_FIRST  = VW'(V_START);
  localparam logic [VW-1:0] Y_LAST   = VW'(V_LAST);

  logic [HW-1:0] x_nx;
  logic [VW-1:0] y_nx;
  logic          y_adv, frame_adv;
  logic          h_act, v_act, h_blk, v_blk;
  logic signed [3:0] hs_eff, vs_eff;
  int            xo, yo, hd, vd;

`ifdef VIDEO_TIMING_SYNC_SHIFT_EN
  logic signed [3:0] h_shift_q, v_shift_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      h_shift_q <= '0;
      v_shift_q <= '0;
    end else if (cen && frame_adv) begin
      h_shift_q <= h_shift;
      v_shift_q <= v_shift;
    end
  end

  // The frame-start edge already uses the freshly sampled shift.
  assign hs_eff = frame_adv ? h_shift : h_shift_q;
  assign vs_eff = frame_adv ? v_shift : v_shift_q;
`else
  logic unused_shift;
  assign unused_shift = ^{h_shift, v_shift};
  assign hs_eff = '0;
  assign vs_eff = '0;
`endif

  always_comb begin
    x_nx      = (video_pos_x == X_LAST) ? X_FIRST : video_pos_x + HW'(1);
    y_adv     = (video_pos_x == X_PRE_HS);
    y_nx      = video_pos_y;
    if (y_adv)
      y_nx = (video_pos_y == Y_LAST) ? Y_FIRST : video_pos_y + VW'(1);
    frame_adv = y_adv && (y_nx == Y_FIRST);

    // Offsets into the line/frame; sync windows wrap modulo the total.
    xo = int'(x_nx) - H_START;
    yo = int'(y_nx) - V_START;
    hd = xo - H_FP - int'(hs_eff);
    vd = yo - V_FP - int'(vs_eff);
    if (hd < 0)          hd = hd + H_TOT;
    else if (hd >= H_TOT) hd = hd - H_TOT;
    if (vd < 0)          vd = vd + V_TOT;
    else if (vd >= V_TOT) vd = vd - V_TOT;
    h_act = (hd < H_SYNC);
    v_act = (vd < V_SYNC);
    h_blk = (xo < H_BLK);
    v_blk = (yo < V_BLK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      video_pos_x <= X_FIRST;
      video_pos_y <= Y_FIRST;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      enable      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (cen) begin
        video_pos_x <= x_nx;
        video_pos_y <= y_nx;
        hsync       <= SYNC_POL ? h_act : ~h_act;
        vsync       <= SYNC_POL ? v_act : ~v_act;
        hblank      <= h_blk;
        vblank      <= v_blk;
        enable      <= ~(h_blk | v_blk);
        line_start  <= y_adv;
        frame_start <= frame_adv;
        if (frame_adv) frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // Set has priority over ack; ack needs no cen.
  always_ff @(posedge clk) begin
    if (reset)
      irq <= 1'b0;
    else if (cen && y_adv && (y_nx == irq_line) && irq_en)
      irq <= 1'b1;
    else if (irq_ack)
      irq <= 1'b0;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised raster timing generator and successor to the fixed 256x224 generator. Region sizes, counter widths, start offsets and sync polarity are configurable. Adds line/frame strobes, a frame counter and a latched raster-line interrupt with an ack handshake. Sits between the pixel-clock enable logic and the tilemap/sprite/pixel-mixer pipeline.

Parameters:
HW, 10, horizontal counter width
VW, 9, vertical counter width
H_START, 128, first x value of a line
H_FP, 40, horizontal front porch (pixels)
H_SYNC, 32, hsync width (pixels)
H_BP, 56, horizontal back porch (pixels)
H_DISP, 256, active pixels per line
V_START, 248, first y value of a frame
V_FP, 16, vertical front porch (lines)
V_SYNC, 8, vsync width (lines)
V_BP, 16, vertical back porch (lines)
V_DISP, 224, active lines per frame
SYNC_POL, 0, active sync level (0 = active-low)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
cen  in  1  pixel clock enable
irq_line  in  VW  raster line that raises irq
irq_en  in  1  raster irq enable
irq_ack  in  1  clears irq
h_shift  in  4  signed hsync shift (used only with the optional feature)
v_shift  in  4  signed vsync shift (used only with the optional feature)
video_pos_x  out  HW  horizontal counter
video_pos_y  out  VW  vertical counter
hsync  out  1  horizontal sync, level per SYNC_POL
vsync  out  1  vertical sync, level per SYNC_POL
hblank  out  1  horizontal blank, active-high
vblank  out  1  vertical blank, active-high
enable  out  1  ~(hblank|vblank)
line_start  out  1  one-cen strobe
frame_start  out  1  one-cen strobe
frame_cnt  out  8  frame counter
irq  out  1  raster interrupt, latched

Behaviour:
- H_TOT = H_FP+H_SYNC+H_BP+H_DISP and V_TOT = V_FP+V_SYNC+V_BP+V_DISP. H_START+H_TOT-1 must fit in HW bits and V_START+V_TOT-1 must fit in VW bits; elaboration fails otherwise.
- Region order is the same on both axes: front porch, sync, back porch, display.
- Reset applies on any clk edge, independent of cen:
  - x=H_START, y=V_START, frame_cnt=0, irq=0
  - hblank=1, vblank=1, sync outputs inactive, line_start=0, frame_start=0
- All state advances only on cycles where cen=1. All outputs are registered and consistent with the current x/y; there is no extra pipeline latency.
- x increments each cen cycle. At H_START+H_TOT-1 it wraps to H_START.
- y advances on the cen cycle where x moves from H_START+H_FP-1 to H_START+H_FP, i.e. the same edge hsync goes active. At V_START+V_TOT-1 it wraps to V_START.
- hsync is active while x is in [H_START+H_FP, H_START+H_FP+H_SYNC-1].
- hblank=0 while x is in [H_START+H_FP+H_SYNC+H_BP, H_START+H_TOT-1]; otherwise 1.
- vsync is active while y is in [V_START+V_FP, V_START+V_FP+V_SYNC-1].
- vblank=0 while y is in [V_START+V_FP+V_SYNC+V_BP, V_START+V_TOT-1]; otherwise 1.
- line_start is high for exactly the one cen cycle on which y has just advanced. It is 0 on all other cycles, including non-cen cycles.
- frame_start is line_start qualified by y==V_START.
- frame_cnt increments (mod 256) at the same edge frame_start rises.
- irq: set when a line_start cycle has y==irq_line and irq_en=1. It stays set until irq_ack=1 is sampled on any clk edge (cen not required). If set and ack occur on the same edge, set wins.
- irq_en=0 blocks new sets but does not clear a pending irq.
- irq_line outside [V_START, V_START+V_TOT-1] never fires.
- Reset mid-line returns to the reset state on the next edge, with no partial strobes.

Optional Feature:
VIDEO_TIMING_SYNC_SHIFT_EN
- Defined:
  - h_shift and v_shift (signed, -8..+7) are sampled into internal registers on frame_start only.
  - The hsync window moves by h_shift pixels; the vsync window moves by v_shift lines. Positive values move later.
  - Blank windows, counters, strobes and irq are unaffected.
  - A shifted window that crosses the wrap point wraps modulo H_TOT or V_TOT.
- Not defined: h_shift and v_shift are ignored and the sync windows are exactly as in Behaviour.

Test Plan:
- Reset with cen=1 continuous (defaults) -> x=128, y=248, hblank=1, vblank=1, hsync=1, vsync=1. After 384 cen cycles x is back at 128; hsync is 0 for x=168..199; hblank=0 for x=256..511.
- Run 264 lines -> y runs 248..511 then wraps to 248. vsync=0 for y=264..271. vblank=0 for y=288..511. frame_start pulses once and frame_cnt goes 0->1. 255 more frames -> frame_cnt wraps to 0.
- cen toggling 1-of-4 -> counters advance only on cen cycles, and strobes are exactly one clk wide.
- irq_line=300, irq_en=1 -> irq rises at the y=300 line_start and holds. Pulsing irq_ack clears it. Ack asserted on the set edge of the next frame -> irq stays 1.
- Assert reset at x=400, y=350 for one edge -> the next state is x=128, y=248, irq=0, frame_cnt=0.
- With VIDEO_TIMING_SYNC_SHIFT_EN: h_shift=+4 applied mid-frame -> no change until the next frame_start, then hsync is 0 for x=172..203. h_shift=-8 -> x=160..191. hblank is unchanged in both cases.
